// File: rtl/wfg_wishbone_master_pkg.sv
// Shared types and constants for the wfg Wishbone classic initiator.
package wfg_wishbone_master_pkg;

  // Initiator sequencing: wait for a command, run one bus beat, hold the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  // Default number of BUS cycles tolerated without an acknowledge.
  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/wfg_wishbone_master.sv
// Wishbone classic initiator: one valid/ready command becomes one bus beat,
// and the read data (or a timeout error) comes back on a valid/ready response.
// Optional feature macro: WFG_WB_MASTER_TIMEOUT_EN adds a saturating ack
// timeout; without it the initiator waits for ack indefinitely.
module wfg_wishbone_master
  import wfg_wishbone_master_pkg::*;
#(
  parameter int BUSW = 32
`ifdef WFG_WB_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [BUSW-1:0]   cmd_adr_i,
  input  logic [BUSW-1:0]   cmd_dat_i,
  input  logic [BUSW/8-1:0] cmd_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [BUSW-1:0]   rsp_dat_o,
  output logic              rsp_err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [BUSW-1:0]   wbm_adr_o,
  output logic [BUSW-1:0]   wbm_dat_o,
  output logic [BUSW/8-1:0] wbm_sel_o,
  input  logic              wbm_ack_i,
  input  logic [BUSW-1:0]   wbm_dat_i
);

  wb_state_e state;
  logic      timeout_hit;
  logic      cmd_fire;

  assign cmd_fire = (state == IDLE) && cmd_valid_i;

  // Handshake flags and bus qualifiers decode straight from the state register,
  // so an asynchronous reset drops cyc/stb without waiting for an edge.
  assign cmd_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);
  assign wbm_cyc_o   = (state == BUS);
  assign wbm_stb_o   = (state == BUS);

  // Main sequencer: IDLE -> BUS on command, BUS -> RESP on ack or timeout, RESP -> IDLE on consume.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (cmd_valid_i) state <= BUS;
        BUS:     if (wbm_ack_i || timeout_hit) state <= RESP;
        RESP:    if (rsp_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus request fields are latched on command acceptance and otherwise keep their last value.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
    end else if (cmd_fire) begin
      wbm_we_o  <= cmd_we_i;
      wbm_adr_o <= cmd_adr_i;
      wbm_dat_o <= cmd_dat_i;
      wbm_sel_o <= cmd_sel_i;
    end
  end

  // Response data is captured at the end of the beat: slave data for reads, zero for writes and errors.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rsp_dat_o <= '0;
    end else if (state == BUS) begin
      if (wbm_ack_i) begin
        rsp_dat_o <= wbm_we_o ? '0 : wbm_dat_i;
      end else if (timeout_hit) begin
        rsp_dat_o <= '0;
      end
    end
  end

`ifdef WFG_WB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] to_cnt;

  // The beat gives up on the TIMEOUT-th unacknowledged BUS cycle; an ack on that same cycle wins.
  assign timeout_hit = (state == BUS) && !wbm_ack_i && (to_cnt >= CW'(TIMEOUT - 1));

  // Saturating count of BUS cycles seen without ack, restarted for every new command.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      to_cnt <= '0;
    end else if (cmd_fire) begin
      to_cnt <= '0;
    end else if ((state == BUS) && !wbm_ack_i && (to_cnt != CW'(TIMEOUT))) begin
      to_cnt <= to_cnt + CW'(1);
    end
  end

  // Error flag reflects how the last beat ended and is held through RESP.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rsp_err_o <= 1'b0;
    end else if (state == BUS) begin
      if (wbm_ack_i) begin
        rsp_err_o <= 1'b0;
      end else if (timeout_hit) begin
        rsp_err_o <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wfg_wishbone_master.sv
// Self-checking bench for wfg_wishbone_master: table vectors, randomized
// transactions against a word-array reference model, and hand-written
// sequences for backpressure, reset mid-beat, spurious ack and timeout.
module tb_wfg_wishbone_master;

  logic        clk;
  logic        rstN;
  logic        cmdValid;
  logic        cmdReady;
  logic        cmdWe;
  logic [31:0] cmdAdr;
  logic [31:0] cmdDat;
  logic [3:0]  cmdSel;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspDat;
  logic        rspErr;
  logic        wbCyc;
  logic        wbStb;
  logic        wbWe;
  logic [31:0] wbAdr;
  logic [31:0] wbDatOut;
  logic [3:0]  wbSel;
  logic        wbAck;
  logic [31:0] wbDatIn;

  logic        slvAck;
  logic        spuriousAck;
  int          slvCnt;
  int          slaveLat;
  logic [31:0] slvMem [16];
  logic [31:0] refMem [16];

  int errCount;
  int checkCount;

  assign wbAck = slvAck | spuriousAck;

  wfg_wishbone_master dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rstN),
    .cmd_valid_i (cmdValid),
    .cmd_ready_o (cmdReady),
    .cmd_we_i    (cmdWe),
    .cmd_adr_i   (cmdAdr),
    .cmd_dat_i   (cmdDat),
    .cmd_sel_i   (cmdSel),
    .rsp_valid_o (rspValid),
    .rsp_ready_i (rspReady),
    .rsp_dat_o   (rspDat),
    .rsp_err_o   (rspErr),
    .wbm_cyc_o   (wbCyc),
    .wbm_stb_o   (wbStb),
    .wbm_we_o    (wbWe),
    .wbm_adr_o   (wbAdr),
    .wbm_dat_o   (wbDatOut),
    .wbm_sel_o   (wbSel),
    .wbm_ack_i   (wbAck),
    .wbm_dat_i   (wbDatIn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish (actual=hung, required=finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  // Slave register file: acks slaveLat cycles after strobe is first seen (0 = never),
  // and commits byte-masked writes on the edge where the master samples ack.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      slvAck  <= 1'b0;
      slvCnt  <= 0;
      wbDatIn <= 32'h0;
    end else if (slvAck) begin
      slvAck <= 1'b0;
      slvCnt <= 0;
      if (wbWe) begin
        for (int b = 0; b < 4; b++) begin
          if (wbSel[b]) slvMem[wbAdr[5:2]][8*b +: 8] <= wbDatOut[8*b +: 8];
        end
      end
    end else if (wbCyc && wbStb) begin
      if ((slaveLat != 0) && (slvCnt + 1 == slaveLat)) begin
        slvAck  <= 1'b1;
        wbDatIn <= slvMem[wbAdr[5:2]];
      end
      slvCnt <= slvCnt + 1;
    end else begin
      slvCnt <= 0;
    end
  end

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] dat,
                                             input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Runs one command from a negedge and reports what the bus and response looked like.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input int lat, input int stall,
                               output logic [31:0] rdat, output logic err, output int latency,
                               output int cycCycles, output logic stableOk);
    int guard;
    logic [31:0] held;
    slaveLat  = lat;
    cmdWe     = we;
    cmdAdr    = adr;
    cmdDat    = dat;
    cmdSel    = sel;
    cmdValid  = 1'b1;
    rspReady  = (stall == 0);
    stableOk  = 1'b1;
    cycCycles = 0;
    guard     = 0;
    while (!cmdReady && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    cmdValid = 1'b0;
    latency  = 1;
    while (!rspValid && latency < 200) begin
      if (wbCyc) begin
        cycCycles++;
        if (wbStb !== 1'b1 || wbWe !== we || wbAdr !== adr || wbDatOut !== dat || wbSel !== sel)
          stableOk = 1'b0;
      end
      @(negedge clk);
      latency++;
    end
    rdat = rspDat;
    err  = rspErr;
    held = rspDat;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!rspValid || rspDat !== held || cmdReady || wbCyc) stableOk = 1'b0;
    end
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    if (rspValid || !cmdReady) stableOk = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          lat;
    logic [31:0] expRdat;
    int          expLat;
    int          expCyc;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] rdat;
    logic        err;
    int          latency;
    int          cycCycles;
    logic        stableOk;
    logic [31:0] held;
    logic        ok;
    int          guard;

    errCount    = 0;
    checkCount  = 0;
    cmdValid    = 1'b0;
    cmdWe       = 1'b0;
    cmdAdr      = 32'h0;
    cmdDat      = 32'h0;
    cmdSel      = 4'h0;
    rspReady    = 1'b0;
    spuriousAck = 1'b0;
    slaveLat    = 1;
    for (int i = 0; i < 16; i++) begin
      slvMem[i] = 32'h0;
      refMem[i] = 32'h0;
    end

    vecs[0] = '{1'b1, 32'h4,  32'h0000_1000, 4'hF, 1, 32'h0000_0000, 3, 2};
    vecs[1] = '{1'b0, 32'h4,  32'h0,         4'hF, 1, 32'h0000_1000, 3, 2};
    vecs[2] = '{1'b1, 32'h8,  32'h0000_4000, 4'hF, 2, 32'h0000_0000, 4, 3};
    vecs[3] = '{1'b0, 32'h8,  32'h0,         4'hF, 1, 32'h0000_4000, 3, 2};
    vecs[4] = '{1'b1, 32'h10, 32'hAABB_CCDD, 4'h5, 3, 32'h0000_0000, 5, 4};
    vecs[5] = '{1'b0, 32'h10, 32'h0,         4'hF, 2, 32'h00BB_00DD, 4, 3};

    rstN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset cmd_ready", {31'h0, cmdReady}, 32'h1);
    checkOutput("reset rsp_valid", {31'h0, rspValid}, 32'h0);
    checkOutput("reset rsp_err", {31'h0, rspErr}, 32'h0);
    checkOutput("reset rsp_dat", rspDat, 32'h0);
    checkOutput("reset cyc_stb_we", {29'h0, wbCyc, wbStb, wbWe}, 32'h0);
    checkOutput("reset adr", wbAdr, 32'h0);
    checkOutput("reset dat_sel", wbDatOut | {28'h0, wbSel}, 32'h0);
    rstN = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].we, vecs[v].adr, vecs[v].dat, vecs[v].sel, vecs[v].lat, 0,
                    rdat, err, latency, cycCycles, stableOk);
      checkOutput($sformatf("vec%0d rdat", v), rdat, vecs[v].expRdat);
      checkOutput($sformatf("vec%0d err", v), {31'h0, err}, 32'h0);
      checkOutput($sformatf("vec%0d latency", v), latency, vecs[v].expLat);
      checkOutput($sformatf("vec%0d cyc cycles", v), cycCycles, vecs[v].expCyc);
      checkOutput($sformatf("vec%0d stable", v), {31'h0, stableOk}, 32'h1);
      if (vecs[v].we) refMem[vecs[v].adr[5:2]] = mergeBytes(refMem[vecs[v].adr[5:2]], vecs[v].dat, vecs[v].sel);
    end
    checkOutput("slave reg 0x4 holds write", slvMem[1], 32'h0000_1000);

    for (int t = 0; t < 30; t++) begin
      logic        we;
      int          idx;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          lat;
      int          stall;
      logic [31:0] expRdat;
      we    = 1'($urandom_range(0, 1));
      idx   = $urandom_range(0, 15);
      dat   = $urandom;
      sel   = 4'($urandom_range(0, 15));
      lat   = $urandom_range(1, 4);
      stall = $urandom_range(0, 3);
      expRdat = we ? 32'h0 : refMem[idx];
      applyStimulus(we, 32'(idx * 4), dat, sel, lat, stall, rdat, err, latency, cycCycles, stableOk);
      checkOutput($sformatf("rand%0d rdat", t), rdat, expRdat);
      checkOutput($sformatf("rand%0d latency", t), latency, lat + 2);
      checkOutput($sformatf("rand%0d cyc+stable", t), {cycCycles[30:0], stableOk}, {31'(lat + 1), 1'b1});
      if (we) refMem[idx] = mergeBytes(refMem[idx], dat, sel);
    end

    // Backpressure: response held five cycles while a second command waits.
    slaveLat = 1;
    cmdWe = 1'b0; cmdAdr = 32'h4; cmdDat = 32'h0; cmdSel = 4'hF; cmdValid = 1'b1;
    @(negedge clk);
    cmdValid = 1'b0;
    guard = 0;
    while (!rspValid && guard < 50) begin @(negedge clk); guard++; end
    checkOutput("bp response arrives", {31'h0, rspValid}, 32'h1);
    held = rspDat;
    checkOutput("bp rdat", held, refMem[1]);
    cmdWe = 1'b1; cmdAdr = 32'h20; cmdDat = 32'h1234_5678; cmdSel = 4'hF; cmdValid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!rspValid || rspDat !== held || cmdReady || wbCyc) ok = 1'b0;
    end
    checkOutput("bp held stable", {31'h0, ok}, 32'h1);
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput("bp release valid/ready", {30'h0, rspValid, cmdReady}, 32'h1);
    @(negedge clk);
    cmdValid = 1'b0;
    checkOutput("bp second cmd accepted", {31'h0, wbCyc}, 32'h1);
    guard = 0;
    while (!rspValid && guard < 50) begin @(negedge clk); guard++; end
    checkOutput("bp second rsp", {31'h0, rspValid}, 32'h1);
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    refMem[8] = 32'h1234_5678;

    // Reset asserted mid-beat: bus and response flags drop before any clock edge.
    slaveLat = 0;
    cmdWe = 1'b0; cmdAdr = 32'h8; cmdSel = 4'hF; cmdValid = 1'b1;
    @(negedge clk);
    cmdValid = 1'b0;
    @(negedge clk);
    checkOutput("mid-bus cyc before reset", {31'h0, wbCyc}, 32'h1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("async reset drops cyc/stb/valid", {29'h0, wbCyc, wbStb, rspValid}, 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("after reset cmd_ready", {31'h0, cmdReady}, 32'h1);
    applyStimulus(1'b0, 32'h8, 32'h0, 4'hF, 1, 0, rdat, err, latency, cycCycles, stableOk);
    checkOutput("after reset read", rdat, refMem[2]);
    checkOutput("after reset latency", latency, 3);

    // Spurious ack in IDLE must not start anything.
    spuriousAck = 1'b1;
    @(negedge clk);
    @(negedge clk);
    spuriousAck = 1'b0;
    checkOutput("idle ack ignored", {29'h0, wbCyc, rspValid, cmdReady}, 32'h1);

    // Spurious ack in RESP must not disturb the held response.
    slaveLat = 1;
    cmdWe = 1'b0; cmdAdr = 32'h20; cmdSel = 4'hF; cmdValid = 1'b1;
    @(negedge clk);
    cmdValid = 1'b0;
    guard = 0;
    while (!rspValid && guard < 50) begin @(negedge clk); guard++; end
    held = rspDat;
    checkOutput("resp read data", held, refMem[8]);
    spuriousAck = 1'b1;
    @(negedge clk);
    spuriousAck = 1'b0;
    checkOutput("resp ack ignored", {30'h0, rspValid, wbCyc}, 32'h2);
    checkOutput("resp ack data held", rspDat, held);
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (rspValid || wbCyc) ok = 1'b0;
      @(negedge clk);
    end
    checkOutput("no extra response", {31'h0, ok}, 32'h1);

`ifdef WFG_WB_MASTER_TIMEOUT_EN
    applyStimulus(1'b0, 32'hC, 32'h0, 4'hF, 0, 0, rdat, err, latency, cycCycles, stableOk);
    checkOutput("timeout cyc cycles", cycCycles, 16);
    checkOutput("timeout err", {31'h0, err}, 32'h1);
    checkOutput("timeout rdat", rdat, 32'h0);
    applyStimulus(1'b0, 32'h4, 32'h0, 4'hF, 15, 0, rdat, err, latency, cycCycles, stableOk);
    checkOutput("ack at limit cyc cycles", cycCycles, 16);
    checkOutput("ack at limit err", {31'h0, err}, 32'h0);
    checkOutput("ack at limit rdat", rdat, refMem[1]);
`else
    applyStimulus(1'b0, 32'h4, 32'h0, 4'hF, 20, 0, rdat, err, latency, cycCycles, stableOk);
    checkOutput("slow slave cyc cycles", cycCycles, 21);
    checkOutput("slow slave err", {31'h0, err}, 32'h0);
    checkOutput("slow slave rdat", rdat, refMem[1]);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/wfg_wishbone_master.md
# wfg_wishbone_master

Wishbone classic initiator that turns single-word commands from a valid/ready request port into one Wishbone bus cycle each, then returns read data or an error on a valid/ready response port. It lets on-chip sequencers and test controllers drive the wfg peripheral register slaves without a CPU. One transaction is outstanding at a time. An optional bus timeout protects against slaves that never acknowledge.

## Interface
- BUSW, 32, data and address width
- TIMEOUT, 16, maximum BUS-state cycles to wait for ack (≥2; used only with timeout enabled)

- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  reset; one clock, asynchronous assert, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid && ready
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  BUSW  address
- cmd_dat_i  in  BUSW  write data
- cmd_sel_i  in  BUSW/8  byte selects
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid && ready
- rsp_dat_o  out  BUSW  read data; 0 for writes and errors
- rsp_err_o  out  1  1 = timeout
- wbm_cyc_o, wbm_stb_o  out  1  Wishbone cycle and strobe; always equal
- wbm_we_o  out  1  write enable
- wbm_adr_o  out  BUSW  address
- wbm_dat_o  out  BUSW  write data
- wbm_sel_o  out  BUSW/8  byte selects
- wbm_ack_i  in  1  slave acknowledge
- wbm_dat_i  in  BUSW  slave read data

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE
  - cmd_ready_o=1.
  - On handshake: register we/adr/dat/sel into the wbm_* outputs, clear the timeout counter, go to BUS.
- BUS
  - cyc=stb=1; all wbm_* outputs held stable.
  - When ack_i is sampled high: capture rsp_dat_o = wbm_dat_i for a read, or 0 for a write. Set rsp_err_o=0 and go to RESP.
- RESP
  - rsp_valid_o=1; rsp_dat_o and rsp_err_o held stable.
  - On rsp_ready_i: go to IDLE.
- cmd_ready_o is 0 in BUS and RESP. No skid buffer; commands presented in those states wait.
- wbm_ack_i is ignored outside BUS.
- wbm_adr_o, wbm_dat_o, wbm_sel_o and wbm_we_o keep their last values in IDLE and RESP. Only cyc/stb qualify them.
- Reset values:
  - state=IDLE, cmd_ready_o=1.
  - rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0.
  - wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_adr_o=wbm_dat_o=wbm_sel_o=0.
- Reset mid-transaction: cyc/stb drop asynchronously; the pending command and response are discarded.

## Timing
- Command handshake at edge N → cyc/stb high from N+1.
- Ack sampled high at edge M:
  - cyc/stb low from M+1 (exactly one acked beat).
  - rsp_valid_o high from M+1.
- Against a slave that acks one cycle after strobe, each beat holds cyc/stb for 2 cycles.
- Handshake-to-response latency = slave ack latency + 2 cycles.
- rsp_ready_i held high: rsp_valid_o lasts 1 cycle and cmd_ready_o returns the next cycle. Back-to-back command period = ack latency + 3 cycles.
- Counter width $clog2(TIMEOUT+1); it saturates and never wraps.

## Configuration
- Macro: WFG_WB_MASTER_TIMEOUT_EN.
- Defined:
  - The counter increments on each BUS cycle with ack low.
  - When it reaches TIMEOUT with ack still low: drop cyc/stb next cycle, rsp_err_o=1, rsp_dat_o=0, go to RESP.
  - Ack sampled in the same cycle the limit is reached: ack wins, no error.
- Undefined:
  - No counter logic; BUS waits indefinitely.
  - rsp_err_o is tied to 0.

## Structure
- Package wfg_wishbone_master_pkg holds:
  - the state enum typedef (IDLE, BUS, RESP);
  - the default TIMEOUT constant (16).
- Single module; no sub-module. The FSM, output registers and counter are inline.

## Test plan
- Write: cmd we=1, adr=0x4, dat=0x0000_1000, sel=0xF; slave acks 1 cycle after stb → one 2-cycle cyc/stb with those values, rsp_valid_o with rsp_dat_o=0, rsp_err_o=0; slave register reads back 0x1000.
- Read: cmd we=0, adr=0x8; slave returns 0x0000_4000 with ack → rsp_dat_o=0x0000_4000, rsp_err_o=0.
- Backpressure: rsp_ready_i=0 for 5 cycles after the response → rsp_valid_o and rsp_dat_o stable; cmd_ready_o=0; a second cmd_valid_i is not accepted until the response handshake.
- Timeout (macro defined, TIMEOUT=16): slave never acks → cyc/stb high for exactly 16 cycles, then rsp_err_o=1, rsp_dat_o=0. With the slave acking on the 16th cycle instead → rsp_err_o=0.
- Reset mid-BUS: assert wb_rst_ni=0 while cyc=1 → cyc/stb/rsp_valid_o go to 0 without waiting for a clock edge; after release cmd_ready_o=1 and the next command completes normally.
- Spurious ack: pulse wbm_ack_i in IDLE and in RESP → no state change, no extra response.
